// File: rtl/serial_det_arbiter.sv
// Round-robin sequencer sharing one serial bit detector between NUM_REQ requesters.
// Optional macro SDA_ERR_CNT_EN adds an 8-bit saturating err_cnt output.
module serial_det_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 8,
  parameter int MAX_LEN = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] bit_in,
  input  logic [NUM_REQ-1:0] last,
  output logic [NUM_REQ-1:0] gnt,
  output logic               det_rst,
  output logic               det_inp,
  input  logic               det_z,
  output logic               done,
  output logic [ID_W-1:0]    done_id,
  output logic [CNT_W-1:0]   result,
  output logic               err,
`ifdef SDA_ERR_CNT_EN
  output logic [7:0]         err_cnt,
`endif
  output logic [1:0]         state_dbg
);

  // Handshake: a requester raises req and holds it until its done pulse; while
  // its gnt is high it presents one bit (and its last flag) per cycle, and
  // dropping req during its grant aborts the frame.

  localparam int BIT_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    cur_id, ptr, pick_id;
  logic               pick_vld;
  logic [CNT_W-1:0]   hit_cnt, hit_nxt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               cur_req, cur_last, abort, at_max, hit_inc;
  logic [NUM_REQ-1:0] gnt_d;
  logic               det_rst_d, done_d, err_d;

  assign state_dbg = state;
  assign cur_req   = req[cur_id];
  assign cur_last  = last[cur_id];
  assign abort     = !cur_req;
  assign at_max    = (bit_cnt == BIT_W'(MAX_LEN - 1));
  assign hit_inc   = det_z && !abort && (hit_cnt != {CNT_W{1'b1}});
  assign hit_nxt   = hit_cnt + CNT_W'(hit_inc);
  assign det_inp   = (state == STREAM) ? bit_in[cur_id] : 1'b0;

  // First active requester above the pointer, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!pick_vld && req[(int'(ptr) + i) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = CLEAR;
      CLEAR:   state_nxt = STREAM;
      STREAM:  if (abort || cur_last || at_max) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered copies line up with it.
  always_comb begin
    gnt_d     = '0;
    det_rst_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (state_nxt == STREAM) gnt_d = NUM_REQ'(1) << cur_id;
    if (state_nxt == CLEAR)  det_rst_d = 1'b1;
    if (state_nxt == REPORT) begin
      done_d = 1'b1;
      err_d  = abort || !cur_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt     <= '0;
      det_rst <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      result  <= '0;
      err     <= 1'b0;
    end else begin
      gnt     <= gnt_d;
      det_rst <= det_rst_d;
      done    <= done_d;
      if (done_d) begin
        done_id <= cur_id;
        result  <= hit_nxt;
        err     <= err_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_id  <= '0;
      ptr     <= ID_W'(NUM_REQ - 1);
      hit_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          cur_id  <= pick_id;
          hit_cnt <= '0;
          bit_cnt <= '0;
        end
        STREAM: begin
          hit_cnt <= hit_nxt;
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
        REPORT: ptr <= cur_id;
        default: ;
      endcase
    end
  end

`ifdef SDA_ERR_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     err_cnt <= '0;
    else if (done_d && err_d && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule
